hilbert_sequencer: RTL

- Control FSM that sequences the Hilbert-transform datapath: the n-tap FIR on the imaginary path and the matching delay line on the real path.
- Loads the FIR coefficients, then gates input samples into the FIR and real-path delay line.
- Zero-pads the FIR after the last sample so the centred convolution outputs are flushed.
- Emits an aligned output-valid strobe and a single done pulse. Datapath registers live outside this block; it drives only strobes, selects and addresses.

---
 rtl/hilbert_sequencer.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/hilbert_sequencer.sv
// rtl/hilbert_sequencer.sv - control sequencer for the Hilbert FIR / real-path delay datapath
module hilbert_sequencer #(
    parameter int LENGTH           = 27,
    parameter int COEFF_ADDR_WIDTH = 5,
    parameter int FIR_LATENCY      = 2
) (
    input  logic                        clock,
    input  logic                        resetN,
    input  logic                        enable,
    input  logic                        sampleValid,
    input  logic                        stopDataIn,
    output logic [COEFF_ADDR_WIDTH-1:0] coeffAddr,
    output logic                        coeffLoad,
    output logic                        firShift,
    output logic                        firInSel,
    output logic                        delayShift,
    output logic                        outValid,
    output logic                        busy,
    output logic                        done
);
    localparam int CW   = COEFF_ADDR_WIDTH;
    localparam int HALF = (LENGTH - 1) / 2;
    localparam int DW   = $clog2(FIR_LATENCY + 1);

    localparam logic [CW-1:0] LAST_ADDR  = CW'(LENGTH - 1);
    localparam logic [CW-1:0] HALF_CNT   = CW'(HALF);
    localparam logic [CW-1:0] FLUSH_LAST = CW'(HALF - 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(FIR_LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_COEFF,
        RUN,
        FLUSH,
        DRAIN
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          addr_q, addr_d;
    logic                   load_q, load_d;
    logic                   shift_q, shift_d;
    logic                   insel_q, insel_d;
    logic                   valid_q, valid_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [CW-1:0]          shift_cnt_q, shift_cnt_d;
    logic [CW-1:0]          flush_cnt_q, flush_cnt_d;
    logic [DW-1:0]          drain_cnt_q, drain_cnt_d;
    logic [FIR_LATENCY-1:0] pipe_q, pipe_d;
    logic                   prod_d;

    always_comb begin
        state_d     = state_q;
        addr_d      = '0;
        load_d      = 1'b0;
        shift_d     = 1'b0;
        insel_d     = 1'b0;
        done_d      = 1'b0;
        prod_d      = 1'b0;
        shift_cnt_d = shift_cnt_q;
        flush_cnt_d = flush_cnt_q;
        drain_cnt_d = drain_cnt_q;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d     = LOAD_COEFF;
                    load_d      = 1'b1;
                    shift_cnt_d = '0;
                    flush_cnt_d = '0;
                    drain_cnt_d = '0;
                end
            end
            LOAD_COEFF: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = RUN;
                end else begin
                    load_d = 1'b1;
                    addr_d = addr_q + CW'(1);
                end
            end
            RUN: begin
                if (sampleValid) begin
                    shift_d = 1'b1;
                    insel_d = 1'b1;
                end
                if (stopDataIn) begin
                    state_d     = FLUSH;
                    flush_cnt_d = '0;
                end
            end
            FLUSH: begin
                shift_d     = 1'b1;
                flush_cnt_d = flush_cnt_q + CW'(1);
                if (flush_cnt_q == FLUSH_LAST) begin
                    state_d     = DRAIN;
                    drain_cnt_d = '0;
                end
            end
            DRAIN: begin
                if (drain_cnt_q == DRAIN_LAST) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    drain_cnt_d = drain_cnt_q + DW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // The first HALF shifts only prime the taps; later ones yield a centred output.
        if (shift_d) begin
            if (shift_cnt_q == HALF_CNT) begin
                prod_d = 1'b1;
            end else begin
                shift_cnt_d = shift_cnt_q + CW'(1);
            end
        end

        pipe_d  = (pipe_q << 1) | FIR_LATENCY'(prod_d);
        valid_d = pipe_q[FIR_LATENCY-1];

        if (state_q != IDLE && !enable) begin
            state_d     = IDLE;
            addr_d      = '0;
            load_d      = 1'b0;
            shift_d     = 1'b0;
            insel_d     = 1'b0;
            done_d      = 1'b0;
            valid_d     = 1'b0;
            pipe_d      = '0;
            shift_cnt_d = '0;
            flush_cnt_d = '0;
            drain_cnt_d = '0;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            load_q      <= 1'b0;
            shift_q     <= 1'b0;
            insel_q     <= 1'b0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            shift_cnt_q <= '0;
            flush_cnt_q <= '0;
            drain_cnt_q <= '0;
            pipe_q      <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            load_q      <= load_d;
            shift_q     <= shift_d;
            insel_q     <= insel_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            shift_cnt_q <= shift_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            pipe_q      <= pipe_d;
        end
    end

    assign coeffAddr  = addr_q;
    assign coeffLoad  = load_q;
    assign firShift   = shift_q;
    assign delayShift = shift_q;
    assign firInSel   = insel_q;
    assign outValid   = valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
